// File: rtl/fetch_queue_pkg.sv
// Shared widths and constants for the instruction fetch queue.
// Bit [0] of a word in the instruction-set numbering is bit [WORD-1] here.
package fetch_queue_pkg;

    localparam int WORD          = 32;
    localparam int PAIR_W        = 2 * WORD;
    localparam int PAIR_BYTES    = PAIR_W / 8;
    localparam int FQ_DEPTH_DFLT = 8;

endpackage

// File: rtl/fetch_queue_if.sv
// Signals between the fetch queue, the local-store instruction port and decode.
// slave = the fetch queue; master = the surrounding core (memory, odd pipe, decode).
interface fetch_queue_if
    import fetch_queue_pkg::*;
#(
    parameter int FQ_DEPTH = FQ_DEPTH_DFLT
) ();

    localparam int CNT_W = $clog2(FQ_DEPTH) + 1;

    logic              imem_req;
    logic [WORD-1:0]   imem_addr;
    logic [PAIR_W-1:0] imem_rdata;
    logic              imem_rvalid;
    logic              redirect;
    logic [WORD-1:0]   redirect_pc;
    logic [1:0]        take;
    logic [WORD-1:0]   instr1;
    logic [WORD-1:0]   instr2;
    logic              valid1;
    logic              valid2;
    logic [WORD-1:0]   pc1;
    logic [CNT_W-1:0]  count;

    modport slave (
        output imem_req, imem_addr,
        input  imem_rdata, imem_rvalid,
        input  redirect, redirect_pc, take,
        output instr1, instr2, valid1, valid2, pc1, count
    );

    modport master (
        input  imem_req, imem_addr,
        output imem_rdata, imem_rvalid,
        output redirect, redirect_pc, take,
        input  instr1, instr2, valid1, valid2, pc1, count
    );

endinterface

// File: rtl/fetch_queue.sv
// Circular instruction queue between the local-store fetch port and dual-issue decode.
// Fetches aligned pairs, presents head/head+1 words, flushes on redirect.
module fetch_queue
    import fetch_queue_pkg::*;
#(
    parameter int FQ_DEPTH = FQ_DEPTH_DFLT,
    parameter int IMEM_LAT = 1
) (
    input  logic          clk,
    input  logic          reset,
    fetch_queue_if.slave  bus
);

    localparam int PTR_W = $clog2(FQ_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WORD-1:0]     r_mem [FQ_DEPTH];
    logic [PTR_W-1:0]    r_head;
    logic [PTR_W-1:0]    r_tail;
    logic [CNT_W-1:0]    r_count;
    logic [WORD-1:0]     r_fetch_pc;
    logic [WORD-1:0]     r_pc1;
    logic [IMEM_LAT-1:0] r_req_pipe;
    logic                r_skip_hi;

    logic             w_inflight;
    logic             w_space_ok;
    logic             w_issue;
    logic             w_accept;
    logic             w_valid1;
    logic             w_valid2;
    logic [1:0]       w_avail;
    logic [1:0]       w_take_n;
    logic [1:0]       w_enq_n;
    logic [PTR_W-1:0] w_tail_p1;
    logic [PTR_W-1:0] w_head_p1;

    // A response is only ours if a surviving request went out IMEM_LAT cycles ago;
    // the request rule reserves room for it, so acceptance never overflows.
    assign w_inflight = r_req_pipe[IMEM_LAT-1];
    assign w_space_ok = (int'(r_count) + 2 * int'(w_inflight) + 2) <= FQ_DEPTH;
    assign w_issue    = reset && !bus.redirect && w_space_ok;
    assign w_accept   = bus.imem_rvalid && w_inflight && !bus.redirect;

    assign w_tail_p1 = r_tail + PTR_W'(1);
    assign w_head_p1 = r_head + PTR_W'(1);

    always_comb begin
        // NOTE: every signal gets a default first so no path infers a latch.
        w_avail  = 2'd0;
        w_take_n = 2'd0;
        w_enq_n  = 2'd0;
        if (r_count >= CNT_W'(2)) w_avail = 2'd2;
        else                      w_avail = {1'b0, r_count[0]};
        if (!bus.redirect) w_take_n = (bus.take > w_avail) ? w_avail : bus.take;
        if (w_accept)      w_enq_n  = r_skip_hi ? 2'd1 : 2'd2;
    end

    // NOTE: storage is deliberately not reset; count gates what is ever observed.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            if (r_skip_hi) begin
                r_mem[r_tail] <= bus.imem_rdata[WORD-1:0];
            end else begin
                r_mem[r_tail]    <= bus.imem_rdata[PAIR_W-1:WORD];
                r_mem[w_tail_p1] <= bus.imem_rdata[WORD-1:0];
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_head     <= '0;
            r_tail     <= '0;
            r_count    <= '0;
            r_fetch_pc <= '0;
            r_pc1      <= '0;
            r_req_pipe <= '0;
            r_skip_hi  <= 1'b0;
        end else if (bus.redirect) begin
            r_head     <= '0;
            r_tail     <= '0;
            r_count    <= '0;
            r_req_pipe <= '0;
            r_fetch_pc <= {bus.redirect_pc[WORD-1:3], 3'b000};
            r_pc1      <= bus.redirect_pc;
            r_skip_hi  <= bus.redirect_pc[2];
        end else begin
            r_head     <= r_head + PTR_W'(w_take_n);
            r_tail     <= r_tail + PTR_W'(w_enq_n);
            r_count    <= r_count + CNT_W'(w_enq_n) - CNT_W'(w_take_n);
            r_pc1      <= r_pc1 + WORD'({w_take_n, 2'b00});
            r_req_pipe <= IMEM_LAT'({r_req_pipe, w_issue});
            if (w_issue)  r_fetch_pc <= r_fetch_pc + WORD'(PAIR_BYTES);
            if (w_accept) r_skip_hi  <= 1'b0;
        end
    end

    assign w_valid1 = (r_count != '0);
    assign w_valid2 = (r_count >= CNT_W'(2));

    // Words are forced to zero when invalid so reset clears them without a clock.
    assign bus.imem_req  = w_issue;
    assign bus.imem_addr = r_fetch_pc;
    assign bus.valid1    = w_valid1;
    assign bus.valid2    = w_valid2;
    assign bus.instr1    = w_valid1 ? r_mem[r_head]    : '0;
    assign bus.instr2    = w_valid2 ? r_mem[w_head_p1] : '0;
    assign bus.pc1       = r_pc1;
    assign bus.count     = r_count;

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: reset, fill to full, steady drain, redirect to an
// odd word with a stale response, mixed take/enqueue, and asynchronous mid-run reset.
module tb_fetch_queue;
    import fetch_queue_pkg::*;

    localparam int DEPTH = 8;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    logic inject_stale = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;

    logic [WORD-1:0] req_addr_s;
    logic            req_s;
    logic [WORD-1:0] pc_exp;

    fetch_queue_if #(.FQ_DEPTH(DEPTH)) bus ();

    fetch_queue #(.FQ_DEPTH(DEPTH), .IMEM_LAT(1)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [WORD-1:0] word_at(input logic [WORD-1:0] a);
        if (a == 32'h0) return 32'h1111_1111;
        if (a == 32'h4) return 32'h2222_2222;
        return 32'hA500_0000 | a;
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One cycle: inputs change just after the rising edge, outputs are checked at the falling edge.
    task automatic next_cycle(input logic [1:0] tk, input logic rd, input logic [WORD-1:0] rpc);
        @(posedge clk);
        #1;
        bus.take        = tk;
        bus.redirect    = rd;
        bus.redirect_pc = rpc;
        @(negedge clk);
    endtask

    task automatic release_reset(input logic [1:0] tk);
        @(posedge clk);
        #1;
        reset    = 1'b1;
        bus.take = tk;
        @(negedge clk);
    endtask

    // Memory model: one-cycle latency, answers the request seen in the previous cycle.
    initial begin
        bus.imem_rvalid = 1'b0;
        bus.imem_rdata  = '0;
        forever begin
            @(negedge clk);
            req_s      = bus.imem_req;
            req_addr_s = bus.imem_addr;
            @(posedge clk);
            #2;
            if (inject_stale) begin
                bus.imem_rvalid = 1'b1;
                bus.imem_rdata  = 64'hDEAD_BEEF_DEAD_BEEF;
            end else begin
                bus.imem_rvalid = req_s;
                bus.imem_rdata  = req_s ? {word_at(req_addr_s), word_at(req_addr_s + 32'd4)} : '0;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.take        = 2'd0;
        bus.redirect    = 1'b0;
        bus.redirect_pc = '0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_req",    bus.imem_req,  1'b0);
        check("rst_addr",   bus.imem_addr, 32'h0);
        check("rst_count",  bus.count,     4'd0);
        check("rst_valid1", bus.valid1,    1'b0);
        check("rst_valid2", bus.valid2,    1'b0);
        check("rst_pc1",    bus.pc1,       32'h0);
        check("rst_instr1", bus.instr1,    32'h0);

        release_reset(2'd0);
        check("c1_req",   bus.imem_req,  1'b1);
        check("c1_addr",  bus.imem_addr, 32'h0);
        check("c1_count", bus.count,     4'd0);

        next_cycle(2'd0, 1'b0, '0);
        check("c2_req",  bus.imem_req,  1'b1);
        check("c2_addr", bus.imem_addr, 32'h8);

        next_cycle(2'd0, 1'b0, '0);
        check("c3_count",  bus.count,     4'd2);
        check("c3_valid1", bus.valid1,    1'b1);
        check("c3_valid2", bus.valid2,    1'b1);
        check("c3_instr1", bus.instr1,    32'h1111_1111);
        check("c3_instr2", bus.instr2,    32'h2222_2222);
        check("c3_pc1",    bus.pc1,       32'h0);
        check("c3_addr",   bus.imem_addr, 32'h10);

        next_cycle(2'd0, 1'b0, '0);
        check("c4_count", bus.count,     4'd4);
        check("c4_req",   bus.imem_req,  1'b1);
        check("c4_addr",  bus.imem_addr, 32'h18);

        next_cycle(2'd0, 1'b0, '0);
        check("c5_count", bus.count,    4'd6);
        check("c5_req",   bus.imem_req, 1'b0);

        for (int c = 6; c <= 9; c++) begin
            next_cycle(2'd0, 1'b0, '0);
            check($sformatf("full%0d_count", c), bus.count,    4'd8);
            check($sformatf("full%0d_req", c),   bus.imem_req, 1'b0);
        end

        // Drain two per cycle; the queue settles at four words with a request every cycle.
        for (int k = 0; k < 8; k++) begin
            next_cycle(2'd2, 1'b0, '0);
            pc_exp = WORD'(8 * k);
            check($sformatf("drain%0d_pc1", k),    bus.pc1,    pc_exp);
            check($sformatf("drain%0d_instr1", k), bus.instr1, word_at(pc_exp));
            check($sformatf("drain%0d_instr2", k), bus.instr2, word_at(pc_exp + 32'd4));
            if (k == 0)      check("drain0_count", bus.count, 4'd8);
            else if (k == 1) check("drain1_count", bus.count, 4'd6);
            else             check($sformatf("drain%0d_count", k), bus.count, 4'd4);
        end

        // Redirect to an odd word while a response is arriving; take is ignored.
        next_cycle(2'd2, 1'b1, 32'h104);
        check("r0_req",   bus.imem_req, 1'b0);
        check("r0_count", bus.count,    4'd4);
        inject_stale = 1'b1;

        next_cycle(2'd0, 1'b0, '0);
        check("r1_count",  bus.count,     4'd0);
        check("r1_valid1", bus.valid1,    1'b0);
        check("r1_pc1",    bus.pc1,       32'h104);
        check("r1_req",    bus.imem_req,  1'b1);
        check("r1_addr",   bus.imem_addr, 32'h100);
        inject_stale = 1'b0;

        next_cycle(2'd0, 1'b0, '0);
        check("r2_count", bus.count,     4'd0);
        check("r2_addr",  bus.imem_addr, 32'h108);

        next_cycle(2'd0, 1'b0, '0);
        check("r3_count",  bus.count,  4'd1);
        check("r3_valid2", bus.valid2, 1'b0);
        check("r3_instr1", bus.instr1, word_at(32'h104));
        check("r3_pc1",    bus.pc1,    32'h104);

        next_cycle(2'd1, 1'b0, '0);
        check("r4_count",  bus.count,  4'd3);
        check("r4_instr1", bus.instr1, word_at(32'h104));
        check("r4_instr2", bus.instr2, word_at(32'h108));

        next_cycle(2'd1, 1'b0, '0);
        check("r5_count",  bus.count,  4'd4);
        check("r5_instr1", bus.instr1, word_at(32'h108));
        check("r5_pc1",    bus.pc1,    32'h108);

        next_cycle(2'd0, 1'b0, '0);
        check("r6_count", bus.count, 4'd5);

        // Asynchronous reset mid-run, away from any clock edge.
        #2;
        reset = 1'b0;
        #1;
        check("arst_req",    bus.imem_req,  1'b0);
        check("arst_addr",   bus.imem_addr, 32'h0);
        check("arst_valid1", bus.valid1,    1'b0);
        check("arst_valid2", bus.valid2,    1'b0);
        check("arst_count",  bus.count,     4'd0);
        check("arst_pc1",    bus.pc1,       32'h0);
        check("arst_instr1", bus.instr1,    32'h0);
        check("arst_instr2", bus.instr2,    32'h0);

        @(posedge clk);
        #1;
        check("arst_hold_count", bus.count, 4'd0);

        // Oversized take on an empty queue must not disturb the pointers.
        release_reset(2'd2);
        check("x1_req",   bus.imem_req,  1'b1);
        check("x1_addr",  bus.imem_addr, 32'h0);
        check("x1_count", bus.count,     4'd0);

        next_cycle(2'd2, 1'b0, '0);
        check("x2_count", bus.count,     4'd0);
        check("x2_addr",  bus.imem_addr, 32'h8);

        next_cycle(2'd0, 1'b0, '0);
        check("x3_count",  bus.count,  4'd2);
        check("x3_instr1", bus.instr1, 32'h1111_1111);
        check("x3_instr2", bus.instr2, 32'h2222_2222);
        check("x3_pc1",    bus.pc1,    32'h0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/fetch_queue.md
FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 SHALL have parameter FQ_DEPTH, default 8, meaning instruction-word capacity of the queue (power of two, at least 4).
REQ-002 SHALL have parameter IMEM_LAT, fixed at 1, meaning cycles from imem_req to imem_rvalid; other values are not supported.
REQ-003 SHALL have port clk, input, 1, meaning the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1, meaning asynchronous active-low reset.
REQ-005 SHALL have port imem_req, output, 1, meaning fetch request for one aligned instruction pair.
REQ-006 SHALL have port imem_addr, output, WORD, meaning byte address of the pair, bits [29:31] always 0.
REQ-007 SHALL have port imem_rdata, input, 2*WORD, meaning returned pair, bits [0:31] at the lower address.
REQ-008 SHALL have port imem_rvalid, input, 1, meaning imem_rdata is valid this cycle.
REQ-009 SHALL have port redirect, input, 1, meaning branch taken or flush from the odd pipe.
REQ-010 SHALL have port redirect_pc, input, WORD, meaning new fetch byte address, word-aligned.
REQ-011 SHALL have port take, input, 2, meaning instructions decode consumes this cycle (0, 1 or 2; 1 when dep_stall_instr2 holds instr2).
REQ-012 SHALL have ports instr1 and instr2, output, WORD each, meaning the head and head+1 queue words.
REQ-013 SHALL have ports valid1 and valid2, output, 1 each, meaning instr1 and instr2 are present.
REQ-014 SHALL have port pc1, output, WORD, meaning byte address of instr1.
REQ-015 SHALL have port count, output, log2(FQ_DEPTH)+1, meaning current occupancy in words.

Function
- REQ-016 SHALL store words in a circular buffer with head and tail pointers wrapping modulo FQ_DEPTH.
- REQ-017 SHALL assert imem_req when reset is high, redirect is low, and count + 2*inflight + 2 <= FQ_DEPTH. inflight is 1 if a request was issued in the previous cycle and not squashed.
- REQ-018 SHALL present imem_addr equal to fetch_pc with bits [29:31] cleared, and advance fetch_pc by 8 on each issued request.
- REQ-019 SHALL enqueue both words of imem_rdata on imem_rvalid. The exception is the first response after a redirect with redirect_pc[29]=1, where only bits [32:63] SHALL be enqueued.
- REQ-020 SHALL drive valid1 = (count>=1) and valid2 = (count>=2) combinationally from the head; instr1, instr2 and pc1 SHALL be don't-care when invalid.
- REQ-021 SHALL clamp take to the number of valid words; a take larger than available is a protocol error and SHALL NOT corrupt pointers.
- REQ-022 SHALL update count as count + enqueued - clamped take when enqueue and dequeue occur in the same cycle.
- REQ-023 SHALL advance pc1 by 4 per dequeued word.
- REQ-024 on redirect SHALL, at the next edge:
  - empty the queue (count=0, head=tail);
  - discard any response arriving in that same cycle or the following cycle that belongs to a pre-redirect request;
  - set fetch_pc and pc1 to redirect_pc;
  - ignore take.
- REQ-025 SHALL give redirect priority over enqueue, dequeue and request issue in the same cycle.
- REQ-026 SHALL tolerate imem_rvalid without an outstanding request by ignoring it.
- REQ-027 SHALL reach full (count=FQ_DEPTH) without overflow; the request rule in REQ-017 SHALL guarantee space for every accepted response.

Reset
- REQ-028 SHALL, while reset is low, force the following values asynchronously:
  - imem_req=0, imem_addr=0;
  - valid1=0, valid2=0, count=0, pc1=0;
  - instr1=0, instr2=0;
  - fetch_pc=0, head=0, tail=0, inflight=0.
- REQ-029 SHALL issue the first request (address 0) in the first cycle after reset deasserts.
- REQ-030 SHALL, when reset asserts mid-operation, drop all queued words and any in-flight response.

Structure
- REQ-031 SHALL take FQ_DEPTH, WORD and the pair width from constants.sv; no new typedefs are required.
- REQ-032 SHALL keep storage as an inline flop array; no sub-module is required, and the block instantiates no children.
- REQ-033 SHALL sit between the local-store instruction port and decode, replacing direct instr1/instr2 delivery.

Verification
- REQ-034 Reset release with memory returning 0x11111111/0x22222222 at 0x0 -> req at 0x0 in cycle 1, valid1=valid2=1 with those words in cycle 3, pc1=0.
- REQ-035 take=0 continuously -> count stops at 8, imem_req low thereafter, no word lost or duplicated.
- REQ-036 Steady take=2 with memory always responding -> count stays constant, pc1 advances by 8 per cycle.
- REQ-037 redirect with redirect_pc=0x104 while a response is in flight -> stale response dropped, req addr 0x100, only the word at 0x104 enqueued, pc1=0x104.
- REQ-038 take=1 on a queue holding 3 words, simultaneous with enqueue of 2 -> count=4, instr1 is the previous instr2.
- REQ-039 reset asserted with count=5 -> all outputs zero immediately, without waiting for a clock edge.
